// File: rtl/dc_pulse_bank.sv
// dc_pulse_bank: a bank of independent retriggerable monostables
// (digital 74123 equivalents) running from one system clock.
//
// Each channel fires on the rising edge of trg = ~a_n & b & clr_n. On a fire,
// the channel loads a down-counter with the selected pulse width W. q is high
// for exactly W clocks. done strobes for one clock after q falls.
//
// Optional build macro DC_PULSE_SYNC_EN: when it is defined, a_n, b and clr_n
// each pass through a two-flop synchroniser before the trigger logic. This
// adds two clocks to every trigger/clear-to-q latency.
module dc_pulse_bank #(
    parameter int CHANNELS           = 2,
    parameter int DC_PULSE_WIDTH_MAX = 255,
    parameter int DC_PULSE_WIDTH_DEF = 100,
    localparam int CNT_WIDTH         = $clog2(DC_PULSE_WIDTH_MAX + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             a_n,
    input  logic [CHANNELS-1:0]             b,
    input  logic [CHANNELS-1:0]             clr_n,
    input  logic [CHANNELS-1:0]             retrig,
    input  logic [CHANNELS-1:0]             use_def,
    input  logic [CHANNELS*CNT_WIDTH-1:0]   width,
    output logic [CHANNELS-1:0]             q,
    output logic [CHANNELS-1:0]             q_n,
    output logic [CHANNELS-1:0]             done
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] WIDTH_DEF = CNT_WIDTH'(DC_PULSE_WIDTH_DEF);

    // Trigger inputs as seen by the channel logic (direct or synchronised).
    logic [CHANNELS-1:0] a_n_eff;
    logic [CHANNELS-1:0] b_eff;
    logic [CHANNELS-1:0] clr_n_eff;

`ifdef DC_PULSE_SYNC_EN
    logic [CHANNELS-1:0] a_n_meta_reg;
    logic [CHANNELS-1:0] a_n_sync_reg;
    logic [CHANNELS-1:0] b_meta_reg;
    logic [CHANNELS-1:0] b_sync_reg;
    logic [CHANNELS-1:0] clr_n_meta_reg;
    logic [CHANNELS-1:0] clr_n_sync_reg;

    // Two-flop synchronisers. They reset to the idle (non-triggering, not cleared) levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_n_meta_reg   <= '1;
            a_n_sync_reg   <= '1;
            b_meta_reg     <= '0;
            b_sync_reg     <= '0;
            clr_n_meta_reg <= '1;
            clr_n_sync_reg <= '1;
        end else begin
            a_n_meta_reg   <= a_n;
            a_n_sync_reg   <= a_n_meta_reg;
            b_meta_reg     <= b;
            b_sync_reg     <= b_meta_reg;
            clr_n_meta_reg <= clr_n;
            clr_n_sync_reg <= clr_n_meta_reg;
        end
    end

    assign a_n_eff   = a_n_sync_reg;
    assign b_eff     = b_sync_reg;
    assign clr_n_eff = clr_n_sync_reg;
`else
    assign a_n_eff   = a_n;
    assign b_eff     = b;
    assign clr_n_eff = clr_n;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_reg;
        logic                 prev_reg;
        logic                 q_reg;
        logic                 done_reg;
        logic                 trg;
        logic                 fire;
        logic                 cnt_nz;
        logic [CNT_WIDTH-1:0] w_sel;

        // Clear participates in the trigger term, so releasing clr_n with
        // a_n=0 and b=1 held is itself a trigger edge (74123 behaviour).
        assign trg    = ~a_n_eff[gi] & b_eff[gi] & clr_n_eff[gi];
        assign fire   = trg & ~prev_reg;
        assign cnt_nz = |cnt_reg;
        assign w_sel  = use_def[gi] ? WIDTH_DEF : width[gi*CNT_WIDTH +: CNT_WIDTH];

        // Counter, output and strobe update. Priority is reset, then clear, then trigger/count.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg  <= '0;
                q_reg    <= 1'b0;
                done_reg <= 1'b0;
                // A trigger level that is already active when reset is released must not fire.
                prev_reg <= 1'b1;
            end else if (!clr_n_eff[gi]) begin
                cnt_reg  <= '0;
                q_reg    <= 1'b0;
                done_reg <= q_reg;
                prev_reg <= 1'b0;
            end else begin
                if (fire && (!cnt_nz || retrig[gi])) begin
                    cnt_reg <= w_sel;
                end else if (cnt_nz) begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                end
                // q follows the old count. A reload on the last count therefore keeps q high without a gap.
                q_reg    <= cnt_nz;
                done_reg <= q_reg & ~cnt_nz;
                prev_reg <= trg;
            end
        end

        assign q[gi]    = q_reg;
        assign q_n[gi]  = ~q_reg;
        assign done[gi] = done_reg;
    end

endmodule
